// File: rtl/wb_lsu_master_if.sv
// Wishbone classic bus between wb_lsu_master and its slaves.
// Signal names are written from the master's side of the bus.
interface wb_lsu_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wb_lsu_master.sv
// Load/store front-end: one CPU request becomes one Wishbone classic cycle, with bounded retry.
// Optional bus timeout is compiled in with WB_LSU_MASTER_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | ready for a request, bus idle
// BUS        | cyc/stb asserted, waiting for ack/err/rty
// BACKOFF    | one bus-idle cycle: before a re-issue, or pacing the error for a rejected request
// RESP       | one-cycle response strobe
module wb_lsu_master #(
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [31:0]     req_addr_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [31:0]     req_wdata_i,
  output logic            rsp_valid_o,
  output logic [31:0]     rsp_rdata_o,
  output logic            rsp_err_o,
  wb_lsu_master_if.master wb
);

  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_BACKOFF, ST_RESP} state_e;

  state_e           state;
  logic [RTY_W-1:0] rty_cnt;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             fault_q;

  logic             req_bad;
  logic [3:0]       sel_nxt;
  logic [31:0]      dat_nxt;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [31:0]      ld_ext;
  logic             bus_timeout;
  logic             bus_done;
  logic             bus_fail;
  logic             bus_retry;

  always_comb begin
    req_bad = 1'b0;
    case (req_size_i)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr_i[0];
      2'b10:   req_bad = |req_addr_i[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    sel_nxt = 4'b1111;
    dat_nxt = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        sel_nxt = 4'b0001 << req_addr_i[1:0];
        dat_nxt = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        sel_nxt = req_addr_i[1] ? 4'b1100 : 4'b0011;
        dat_nxt = {2{req_wdata_i[15:0]}};
      end
      default: begin
        sel_nxt = 4'b1111;
        dat_nxt = req_wdata_i;
      end
    endcase
  end

  // dat_i is only meaningful while ack_i is high; ld_ext is captured only then.
  always_comb begin
    byte_lane = wb.dat_i[7:0];
    case (lane_q)
      2'd0:    byte_lane = wb.dat_i[7:0];
      2'd1:    byte_lane = wb.dat_i[15:8];
      2'd2:    byte_lane = wb.dat_i[23:16];
      default: byte_lane = wb.dat_i[31:24];
    endcase
    half_lane = lane_q[1] ? wb.dat_i[31:16] : wb.dat_i[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      2'b01:   ld_ext = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: ld_ext = wb.dat_i;
    endcase
  end

`ifdef WB_LSU_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_TOP = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [TMO_W-1:0] tmo_cnt;

  // Preloaded whenever not in BUS, so every entry (including after BACKOFF) starts fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state != ST_BUS) begin
      tmo_cnt <= TMO_W'(TMO_TOP);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign bus_timeout = (state == ST_BUS) && (tmo_cnt == '0);
`else
  assign bus_timeout = 1'b0;
`endif

  // Terminations outrank the timeout; among terminations err > ack > rty.
  always_comb begin
    bus_done  = 1'b0;
    bus_fail  = 1'b0;
    bus_retry = 1'b0;
    if (wb.err_i) begin
      bus_done = 1'b1;
      bus_fail = 1'b1;
    end else if (wb.ack_i) begin
      bus_done = 1'b1;
    end else if (wb.rty_i) begin
      if (rty_cnt < RTY_W'(MAX_RETRIES)) begin
        bus_retry = 1'b1;
      end else begin
        bus_done = 1'b1;
        bus_fail = 1'b1;
      end
    end else if (bus_timeout) begin
      bus_done = 1'b1;
      bus_fail = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      wb.cyc_o    <= 1'b0;
      wb.stb_o    <= 1'b0;
      wb.we_o     <= 1'b0;
      wb.adr_o    <= '0;
      wb.sel_o    <= '0;
      wb.dat_o    <= '0;
      rty_cnt     <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            lane_q      <= req_addr_i[1:0];
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            if (req_bad) begin
              fault_q <= 1'b1;
              state   <= ST_BACKOFF;
            end else begin
              wb.cyc_o <= 1'b1;
              wb.stb_o <= 1'b1;
              wb.we_o  <= req_we_i;
              wb.adr_o <= {req_addr_i[31:2], 2'b00};
              wb.sel_o <= sel_nxt;
              wb.dat_o <= dat_nxt;
              state    <= ST_BUS;
            end
          end
        end

        ST_BUS: begin
          if (bus_done) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= bus_fail;
            rsp_rdata_o <= (bus_fail || wb.we_o) ? '0 : ld_ext;
            wb.cyc_o    <= 1'b0;
            wb.stb_o    <= 1'b0;
            wb.we_o     <= 1'b0;
            wb.adr_o    <= '0;
            wb.sel_o    <= '0;
            wb.dat_o    <= '0;
            rty_cnt     <= '0;
            state       <= ST_RESP;
          end else if (bus_retry) begin
            rty_cnt  <= rty_cnt + 1'b1;
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            state    <= ST_BACKOFF;
          end
        end

        ST_BACKOFF: begin
          if (fault_q) begin
            fault_q     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            state       <= ST_RESP;
          end else begin
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
            state    <= ST_BUS;
          end
        end

        ST_RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          rty_cnt     <= '0;
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
